// File: rtl/iq_demod_acc.sv
// Synchronous I/Q demodulator: multiplies each ADC sample by +/-1 per the IP/QP
// references and integrates over a programmable number of excitation periods.
module iq_demod_acc #(
    parameter int SAMPLE_W = 12,
    parameter int ACC_W    = 24
) (
    input  logic                       Clk,
    input  logic                       Resetn,
    input  logic                       Start,
    input  logic                       StepNum,
    input  logic [3:0]                 NumPeriods,
    input  logic                       IP,
    input  logic                       QP,
    input  logic                       SampleValid,
    input  logic signed [SAMPLE_W-1:0] Sample,
    output logic signed [ACC_W-1:0]    ISum,
    output logic signed [ACC_W-1:0]    QSum,
    output logic                       Done,
    output logic                       Busy,
    output logic                       Err
);

    typedef enum logic [1:0] {IDLE, SYNC, ACC, DONE} state_t;

    state_t                    state, state_nxt;
    logic                      ip_q;
    logic                      rise;
    logic                      step_q;
    logic [4:0]                nper_q;
    logic [4:0]                pcnt;
    logic [4:0]                pcnt_inc;
    logic                      last;
    logic [5:0]                scnt;
    logic [5:0]                scnt_exp;
    logic [5:0]                scnt_first;
    logic signed [ACC_W-1:0]   iacc, qacc;
    logic signed [ACC_W-1:0]   iacc_nxt, qacc_nxt;

    // Sign-extend before negating so that -(-2^(SAMPLE_W-1)) is representable.
    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]    acc,
        input logic signed [SAMPLE_W-1:0] s,
        input logic                       pos
    );
        logic signed [ACC_W-1:0] ext;
        ext = {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
        return pos ? acc + ext : acc - ext;
    endfunction

    assign rise       = IP & ~ip_q;
    assign pcnt_inc   = pcnt + 5'd1;
    assign last       = (pcnt_inc == nper_q);
    assign scnt_exp   = step_q ? 6'd16 : 6'd32;
    assign scnt_first = {5'd0, SampleValid};
    assign iacc_nxt   = mac(iacc, Sample, IP);
    assign qacc_nxt   = mac(qacc, Sample, QP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = SYNC;
            SYNC:    if (rise) state_nxt = ACC;
            ACC:     if (rise && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Done = (state == DONE);
    assign Busy = (state == SYNC) || (state == ACC);

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state  <= IDLE;
            ip_q   <= 1'b0;
            step_q <= 1'b0;
            nper_q <= 5'd0;
            pcnt   <= 5'd0;
            scnt   <= 6'd0;
            iacc   <= '0;
            qacc   <= '0;
            ISum   <= '0;
            QSum   <= '0;
            Err    <= 1'b0;
        end else begin
            state <= state_nxt;
            ip_q  <= IP;
            case (state)
                IDLE: begin
                    if (Start) begin
                        step_q <= StepNum;
                        nper_q <= (NumPeriods == 4'd0) ? 5'd16 : {1'b0, NumPeriods};
                        pcnt   <= 5'd0;
                        scnt   <= 6'd0;
                        iacc   <= '0;
                        qacc   <= '0;
                        Err    <= 1'b0;
                    end
                end
                SYNC: begin
                    if (rise) begin
                        if (SampleValid) begin
                            iacc <= iacc_nxt;
                            qacc <= qacc_nxt;
                        end
                        scnt <= scnt_first;
                    end
                end
                ACC: begin
                    if (rise) begin
                        if (scnt != scnt_exp) Err <= 1'b1;
                        pcnt <= pcnt_inc;
                        // The terminating rise's own sample belongs to no period.
                        if (last) begin
                            ISum <= iacc;
                            QSum <= qacc;
                        end else begin
                            if (SampleValid) begin
                                iacc <= iacc_nxt;
                                qacc <= qacc_nxt;
                            end
                            scnt <= scnt_first;
                        end
                    end else if (SampleValid) begin
                        iacc <= iacc_nxt;
                        qacc <= qacc_nxt;
                        scnt <= scnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_demod_acc.sv
// Scoreboard bench for iq_demod_acc: directed measurements push hand-computed
// results; a monitor pops and compares whenever Done is presented.
module tb_iq_demod_acc;

    localparam int SAMPLE_W = 12;
    localparam int ACC_W    = 24;

    logic                       Clk = 1'b0;
    logic                       Resetn = 1'b0;
    logic                       Start = 1'b0;
    logic                       StepNum = 1'b0;
    logic [3:0]                 NumPeriods = 4'd0;
    logic                       IP = 1'b0;
    logic                       QP = 1'b0;
    logic                       SampleValid = 1'b0;
    logic signed [SAMPLE_W-1:0] Sample = '0;
    logic signed [ACC_W-1:0]    ISum, QSum;
    logic                       Done, Busy, Err;

    iq_demod_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .StepNum(StepNum),
        .NumPeriods(NumPeriods), .IP(IP), .QP(QP), .SampleValid(SampleValid),
        .Sample(Sample), .ISum(ISum), .QSum(QSum), .Done(Done), .Busy(Busy),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic signed [ACC_W-1:0] i;
        logic signed [ACC_W-1:0] q;
        logic                    e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("isum", ISum, e.i);
                    chk("qsum", QSum, e.q);
                    chk("err_at_done", Err, e.e);
                end
            end
        end
    end

    // Waveform for cycle k after Start: IP low for half, then square wave; QP lags by half/2.
    task automatic drive_k(input int k, input int half, input int mode,
                           input int gapk, input int ignk);
        int lag;
        lag         = half / 2;
        IP          = ((k / half) % 2) == 1;
        QP          = (k >= lag) && ((((k - lag) / half) % 2) == 1);
        SampleValid = (k != gapk);
        Start       = (k == ignk);
        case (mode)
            0:       Sample = IP ? 12'sd100 : -12'sd100;
            1:       Sample = 12'sd100;
            default: Sample = IP ? -12'sd2048 : 12'sd2047;
        endcase
    endtask

    task automatic do_start(input logic step, input logic [3:0] np);
        @(posedge Clk); #1;
        Start = 1'b1; StepNum = step; NumPeriods = np;
        IP = 1'b0; QP = 1'b0; SampleValid = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("busy_after_start", Busy, 1);
        chk("err_cleared_on_start", Err, 0);
    endtask

    task automatic meas(input logic step, input logic [3:0] np, input int mode,
                        input int gapk, input int ignk,
                        input logic signed [ACC_W-1:0] ei,
                        input logic signed [ACC_W-1:0] eq, input logic ee);
        int   half, nper, term;
        exp_t e;
        half = step ? 8 : 16;
        nper = (np == 4'd0) ? 16 : int'(np);
        term = half + nper * 2 * half;
        e.i = ei; e.q = eq; e.e = ee;
        sb.push_back(e);
        do_start(step, np);
        for (int k = 0; k <= term; k++) begin
            drive_k(k, half, mode, gapk, ignk);
            @(posedge Clk); #1;
        end
        chk("done_after_last_rise", Done, 1);
        chk("busy_low_at_done", Busy, 0);
        Start = 1'b1;
        IP = 1'b0; QP = 1'b0; SampleValid = 1'b0; Sample = '0;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("done_one_cycle", Done, 0);
        chk("start_in_done_ignored", Busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_isum", ISum, 0);
        chk("rst_qsum", QSum, 0);
        chk("rst_done", Done, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_err", Err, 0);
        Resetn = 1'b1;

        // 2 periods of 32, rectified +-100, Start pulsed mid-measurement
        meas(1'b0, 4'd2, 0, -1, 30, 24'sd6400, 24'sd0, 1'b0);
        // constant input demodulates to zero
        meas(1'b0, 4'd2, 1, -1, -1, 24'sd0, 24'sd0, 1'b0);
        // 16 periods of 16 steps: 16*16*100
        meas(1'b1, 4'd0, 0, -1, -1, 24'sd25600, 24'sd0, 1'b0);
        // full-scale: 15 * 16 * (-2048 - 2047)
        meas(1'b0, 4'd15, 2, -1, -1, -24'sd982800, 24'sd0, 1'b0);
        // one missing sample (IP=1, QP=0) in period 1
        meas(1'b0, 4'd1, 0, 21, -1, 24'sd3100, 24'sd100, 1'b1);

        repeat (5) @(posedge Clk);
        #1;
        chk("err_sticky", Err, 1);
        chk("isum_holds", ISum, 3100);

        // reset mid-ACC
        do_start(1'b0, 4'd2);
        for (int k = 0; k < 40; k++) begin
            drive_k(k, 16, 0, -1, -1);
            @(posedge Clk); #1;
        end
        chk("busy_in_acc", Busy, 1);
        Resetn = 1'b0;
        drive_k(40, 16, 0, -1, -1);
        @(posedge Clk); #1;
        Resetn = 1'b1;
        chk("midrst_isum", ISum, 0);
        chk("midrst_qsum", QSum, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_err", Err, 0);
        for (int k = 41; k < 160; k++) begin
            drive_k(k, 16, 0, -1, -1);
            @(posedge Clk); #1;
        end
        chk("idle_after_rst", Busy, 0);
        IP = 1'b0; QP = 1'b0;
        repeat (2) @(posedge Clk);

        // recovery after reset
        meas(1'b0, 4'd2, 0, -1, -1, 24'sd6400, 24'sd0, 1'b0);

        repeat (3) @(posedge Clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
